led_mode_scheduler: RTL and testbench

//  Sequences the LED pattern mux select from UART command bytes.

---
 rtl/led_mode_scheduler.sv | 168 ++++++++++++++++
 tb/tb_led_mode_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_scheduler.sv
// led_mode_scheduler: turns UART command bytes into the LED pattern mux select.
// A requested mode is held as pending and is only applied at a WS2812 frame
// boundary, so the driver never switches pattern in the middle of a frame.
// Optional auto-cycle feature: define LED_MODE_AUTO_CYCLE_EN to enable the 'a'
// command, which steps the select 00->01->10->00 every CYCLE_FRAMES frames.
`timescale 1ns/1ps

module led_mode_scheduler #(
    parameter int WIDTH_UART   = 8,
    parameter int WIDTH_SEL    = 2,
    parameter int CYCLE_FRAMES = 60
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [WIDTH_UART-1:0] i_uart_data,
    input  logic                  i_uart_valid,
    input  logic                  i_frame_done,
    output logic [WIDTH_SEL-1:0]  o_sel_mux,
    output logic                  o_sel_pending,
    output logic                  o_cmd_err,
    output logic                  o_auto
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [WIDTH_SEL-1:0] SEL_OFF = '1;

    state_t               state;
    logic [WIDTH_SEL-1:0] sel_mux_q;
    logic [WIDTH_SEL-1:0] pending_q;
    logic                 sel_pending_q;
    logic                 cmd_err_q;

    logic                 is_mode;
    logic                 is_auto_cmd;
    logic                 is_bad;
    logic [WIDTH_SEL-1:0] target;
    logic                 mode_cmd;
    logic                 auto_cmd;

    // Classify the incoming byte and map mode digits to a select value.
    always_comb begin
        is_mode     = 1'b0;
        is_auto_cmd = 1'b0;
        target      = SEL_OFF;
        if (i_uart_data == WIDTH_UART'('h30)) begin
            is_mode = 1'b1;
            target  = SEL_OFF;
        end else if (i_uart_data == WIDTH_UART'('h31)) begin
            is_mode = 1'b1;
            target  = WIDTH_SEL'(0);
        end else if (i_uart_data == WIDTH_UART'('h32)) begin
            is_mode = 1'b1;
            target  = WIDTH_SEL'(1);
        end else if (i_uart_data == WIDTH_UART'('h33)) begin
            is_mode = 1'b1;
            target  = WIDTH_SEL'(2);
        end
`ifdef LED_MODE_AUTO_CYCLE_EN
        else if (i_uart_data == WIDTH_UART'('h61)) begin
            is_auto_cmd = 1'b1;
        end
`endif
        is_bad = ~is_mode & ~is_auto_cmd;
    end

    assign mode_cmd = i_uart_valid & is_mode;
    assign auto_cmd = i_uart_valid & is_auto_cmd;

`ifdef LED_MODE_AUTO_CYCLE_EN
    localparam int CNT_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_FRAMES - 1);

    logic             auto_q;
    logic [CNT_W-1:0] frame_cnt_q;

    // Auto-cycle order: 00 -> 01 -> 10 -> 00; "off" (11) re-enters at 00.
    function automatic logic [WIDTH_SEL-1:0] next_step(input logic [WIDTH_SEL-1:0] s);
        if (s == WIDTH_SEL'(0))
            return WIDTH_SEL'(1);
        else if (s == WIDTH_SEL'(1))
            return WIDTH_SEL'(2);
        else
            return WIDTH_SEL'(0);
    endfunction

    assign o_auto = auto_q;
`else
    assign o_auto = 1'b0;
`endif

    // Command FSM: track the pending select and commit it on a frame boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= RUN;
            sel_mux_q     <= SEL_OFF;
            pending_q     <= SEL_OFF;
            sel_pending_q <= 1'b0;
            cmd_err_q     <= 1'b0;
`ifdef LED_MODE_AUTO_CYCLE_EN
            auto_q        <= 1'b0;
            frame_cnt_q   <= '0;
`endif
        end else begin
            cmd_err_q <= i_uart_valid & is_bad;
`ifdef LED_MODE_AUTO_CYCLE_EN
            // 'a' wins over everything else this cycle, including a frame boundary.
            if (auto_cmd) begin
                auto_q        <= 1'b1;
                frame_cnt_q   <= '0;
                state         <= RUN;
                sel_pending_q <= 1'b0;
            end else
`endif
            if (mode_cmd) begin
`ifdef LED_MODE_AUTO_CYCLE_EN
                auto_q      <= 1'b0;
                frame_cnt_q <= '0;
`endif
                if (state == PEND && i_frame_done) begin
                    // Old pending value commits now; the new byte is judged
                    // against the value that is being committed.
                    sel_mux_q <= pending_q;
                    if (target != pending_q) begin
                        state         <= PEND;
                        pending_q     <= target;
                        sel_pending_q <= 1'b1;
                    end else begin
                        state         <= RUN;
                        sel_pending_q <= 1'b0;
                    end
                end else if (target != sel_mux_q) begin
                    // A boundary arriving in RUN never commits this same cycle.
                    state         <= PEND;
                    pending_q     <= target;
                    sel_pending_q <= 1'b1;
                end else begin
                    state         <= RUN;
                    sel_pending_q <= 1'b0;
                end
            end else if (i_frame_done) begin
                if (state == PEND) begin
                    sel_mux_q     <= pending_q;
                    state         <= RUN;
                    sel_pending_q <= 1'b0;
                end
`ifdef LED_MODE_AUTO_CYCLE_EN
                else if (auto_q) begin
                    if (frame_cnt_q == CNT_LAST) begin
                        frame_cnt_q <= '0;
                        sel_mux_q   <= next_step(sel_mux_q);
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end
`endif
            end
        end
    end

    assign o_sel_mux     = sel_mux_q;
    assign o_sel_pending = sel_pending_q;
    assign o_cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Testbench for led_mode_scheduler: directed scenarios followed by random
// command/frame traffic, compared cycle by cycle against a behavioural model.
`timescale 1ns/1ps

module tb_led_mode_scheduler;

    localparam int CF = 3;
`ifdef LED_MODE_AUTO_CYCLE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       uart_valid = 1'b0;
    logic       frame_done = 1'b0;
    logic [1:0] sel_mux;
    logic       sel_pending;
    logic       cmd_err;
    logic       auto_o;

    always #5 clk = ~clk;

    led_mode_scheduler #(
        .WIDTH_UART  (8),
        .WIDTH_SEL   (2),
        .CYCLE_FRAMES(CF)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_uart_data  (uart_data),
        .i_uart_valid (uart_valid),
        .i_frame_done (frame_done),
        .o_sel_mux    (sel_mux),
        .o_sel_pending(sel_pending),
        .o_cmd_err    (cmd_err),
        .o_auto       (auto_o)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       pend;
        logic       err;
        logic       aut;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: committed select, optional pending target, auto state.
    int m_sel;
    int m_pend_tgt;
    bit m_has_pend;
    bit m_auto;
    int m_cnt;

    function automatic void model_reset();
        m_sel      = 3;
        m_pend_tgt = 3;
        m_has_pend = 1'b0;
        m_auto     = 1'b0;
        m_cnt      = 0;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got sel=%0d pend=%0d err=%0d auto=%0d, expected sel=%0d pend=%0d err=%0d auto=%0d",
                     name, $time, act.sel, act.pend, act.err, act.aut,
                     exp_v.sel, exp_v.pend, exp_v.err, exp_v.aut);
        end
    endtask

    // Drive one cycle of inputs, advance the model, queue what the DUT must show.
    task automatic step(input bit v, input logic [7:0] d, input bit fd);
        obs_t e;
        bit   mode;
        bit   err;
        int   tgt;
        @(negedge clk);
        uart_valid = v;
        uart_data  = d;
        frame_done = fd;
        mode = v && (d >= 8'h30) && (d <= 8'h33);
        tgt  = (d == 8'h30) ? 3 : (int'(d) - 'h31);
        err  = 1'b0;
        if (v && AUTO_EN && d == 8'h61) begin
            m_auto     = 1'b1;
            m_cnt      = 0;
            m_has_pend = 1'b0;
        end else if (mode) begin
            m_auto = 1'b0;
            m_cnt  = 0;
            if (m_has_pend && fd) m_sel = m_pend_tgt;
            m_has_pend = (tgt != m_sel);
            m_pend_tgt = tgt;
        end else begin
            err = v;
            if (fd) begin
                if (m_has_pend) begin
                    m_sel      = m_pend_tgt;
                    m_has_pend = 1'b0;
                end else if (m_auto) begin
                    m_cnt++;
                    if (m_cnt == CF) begin
                        m_cnt = 0;
                        m_sel = (m_sel >= 2) ? 0 : m_sel + 1;
                    end
                end
            end
        end
        e.sel  = 2'(m_sel);
        e.pend = m_has_pend;
        e.err  = err;
        e.aut  = m_auto;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    // Asynchronous reset between clock edges, checked before any edge arrives.
    task automatic do_reset();
        obs_t rst_exp;
        @(negedge clk);
        uart_valid = 1'b0;
        frame_done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        rst_exp = '{sel: 2'b11, pend: 1'b0, err: 1'b0, aut: 1'b0};
        check("async_reset", {sel_mux, sel_pending, cmd_err, auto_o}, rst_exp);
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: every cycle the DUT registers a new output word; compare it.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", {sel_mux, sel_pending, cmd_err, auto_o}, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t       rst_exp;
        logic [7:0] d;
        model_reset();
        repeat (2) @(negedge clk);
        rst_exp = '{sel: 2'b11, pend: 1'b0, err: 1'b0, aut: 1'b0};
        check("reset_state", {sel_mux, sel_pending, cmd_err, auto_o}, rst_exp);
        rst_n = 1'b1;

        // Request 01, then commit it at a frame boundary.
        step(1'b1, 8'h32, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        // Two requests before one boundary: last one wins.
        step(1'b1, 8'h31, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        idle(1);
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        // Command and boundary together in RUN: commit waits for the next boundary.
        step(1'b1, 8'h31, 1'b1);
        idle(1);
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        // Bad byte, then the current select again.
        step(1'b1, 8'h7A, 1'b0);
        idle(2);
        step(1'b1, 8'h31, 1'b0);
        idle(1);
        // Command and boundary together in PEND.
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h32, 1'b0);
        step(1'b1, 8'h33, 1'b1);
        idle(1);
        // Auto-cycle from off.
        step(1'b1, 8'h30, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        step(1'b1, 8'h61, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'h00, 1'b1);
            idle(1);
        end
        step(1'b1, 8'h61, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h32, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        // Reset while a change is pending.
        step(1'b1, 8'h31, 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: d = 8'h30;
                1: d = 8'h31;
                2: d = 8'h32;
                3: d = 8'h33;
                4: d = 8'h61;
                default: d = 8'($urandom);
            endcase
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                step($urandom_range(0, 99) < 30, d, $urandom_range(0, 99) < 20);
        end
        step(1'b0, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
